rf_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between EXU (ALU/CSR result) and LSU (load data) writeback.

---
 rtl/rf_wb_arbiter.sv | 86 ++++++++
 tb/tb_rf_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin EXU/LSU sharing of the single
// RF write port, plus a per-register busy scoreboard that stalls issue on RAW/WAW.
module rf_wb_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_NUM     = 32,
   parameter int REG_NUM_BIT = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   exu_valid,
   input  logic [REG_NUM_BIT-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0]  exu_data,
   output logic                   exu_ready,
   input  logic                   lsu_valid,
   input  logic [REG_NUM_BIT-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0]  lsu_data,
   output logic                   lsu_ready,
   input  logic                   iss_valid,
   input  logic                   iss_rd_en,
   input  logic [REG_NUM_BIT-1:0] iss_rd,
   input  logic [REG_NUM_BIT-1:0] iss_rs1,
   input  logic [REG_NUM_BIT-1:0] iss_rs2,
   output logic                   iss_stall,
   output logic                   rf_wen,
   output logic [REG_NUM_BIT-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]  rf_wdata,
   output logic [REG_NUM-1:0]     busy_vec,
   output logic                   wb_err
);

   logic                   last_lsu;
   logic                   exu_gnt;
   logic                   lsu_gnt;
   logic                   hs;
   logic                   wb_live;
   logic [REG_NUM_BIT-1:0] wb_rd;
   logic [DATA_WIDTH-1:0]  wb_data;
   logic [REG_NUM-1:0]     busy_d;
   logic                   iss_fire;

   // On a tie, the side that did not win last time gets the port
   always_comb begin
      exu_gnt = exu_valid & (~lsu_valid | last_lsu);
      lsu_gnt = lsu_valid & (~exu_valid | ~last_lsu);
   end

   assign exu_ready = exu_gnt;
   assign lsu_ready = lsu_gnt;
   assign hs        = exu_gnt | lsu_gnt;
   assign wb_rd     = lsu_gnt ? lsu_rd : exu_rd;
   assign wb_data   = lsu_gnt ? lsu_data : exu_data;
   assign wb_live   = hs & (wb_rd != '0);

   assign iss_stall = iss_valid & (busy_vec[iss_rs1] | busy_vec[iss_rs2]
                    | (iss_rd_en & busy_vec[iss_rd]));
   assign iss_fire  = iss_valid & iss_rd_en & ~iss_stall & (iss_rd != '0);

   // Set after clear so a (stall-prevented) collision keeps the bit busy
   always_comb begin
      busy_d = busy_vec;
      if (rf_wen) busy_d[rf_waddr] = 1'b0;
      if (iss_fire) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_lsu <= 1'b1;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy_vec <= '0;
         wb_err   <= 1'b0;
      end else begin
         if (hs) last_lsu <= lsu_gnt;
         rf_wen   <= wb_live;
         if (wb_live) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
         busy_vec <= busy_d;
         if (wb_live & ~busy_vec[wb_rd]) wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, tie round-robin,
// hazard stalls, x0 writes and the sticky writeback error flag.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        exu_valid;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        exu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        iss_valid;
   logic        iss_rd_en;
   logic [4:0]  iss_rd;
   logic [4:0]  iss_rs1;
   logic [4:0]  iss_rs2;
   logic        iss_stall;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_vec;
   logic        wb_err;

   int errors = 0;
   int checks = 0;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .exu_valid (exu_valid),
      .exu_rd    (exu_rd),
      .exu_data  (exu_data),
      .exu_ready (exu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .iss_valid (iss_valid),
      .iss_rd_en (iss_rd_en),
      .iss_rd    (iss_rd),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_stall (iss_stall),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .busy_vec  (busy_vec),
      .wb_err    (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [4:0] rd);
      iss_valid = 1'b1;
      iss_rd_en = 1'b1;
      iss_rd    = rd;
      iss_rs1   = 5'd0;
      iss_rs2   = 5'd0;
      step();
      iss_valid = 1'b0;
      iss_rd_en = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      iss_valid = 1'b0; iss_rd_en = 1'b0;
      iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
      #3;
      chk("rst_wen", {31'd0, rf_wen}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_err", {31'd0, wb_err}, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // reset in the middle of a pending write
      dispatch(5'd2);
      chk("t1_busy", busy_vec, 32'h4);
      exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h55;
      #1;
      chk("t1_ready", {31'd0, exu_ready}, 32'd1);
      step();
      exu_valid = 1'b0;
      chk("t1_wen", {31'd0, rf_wen}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t1_rst_wen", {31'd0, rf_wen}, 32'd0);
      chk("t1_rst_busy", busy_vec, 32'd0);
      chk("t1_rst_err", {31'd0, wb_err}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // single EXU writeback
      dispatch(5'd5);
      chk("t2_busy", busy_vec, 32'h20);
      step();
      exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
      #1;
      chk("t2_ready", {31'd0, exu_ready}, 32'd1);
      chk("t2_lready", {31'd0, lsu_ready}, 32'd0);
      step();
      exu_valid = 1'b0;
      chk("t2_wen", {31'd0, rf_wen}, 32'd1);
      chk("t2_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
      chk("t2_busy_wr", busy_vec, 32'h20);
      step();
      chk("t2_wen_off", {31'd0, rf_wen}, 32'd0);
      chk("t2_busy_clr", busy_vec, 32'd0);
      chk("t2_wdata_hold", rf_wdata, 32'hDEADBEEF);
      chk("t2_err", {31'd0, wb_err}, 32'd0);

      // x0 writeback from LSU
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
      #1;
      chk("t5_ready", {31'd0, lsu_ready}, 32'd1);
      step();
      lsu_valid = 1'b0;
      chk("t5_wen", {31'd0, rf_wen}, 32'd0);
      chk("t5_busy", busy_vec, 32'd0);
      chk("t5_err", {31'd0, wb_err}, 32'd0);

      // tie: EXU first (LSU won last), then alternate
      dispatch(5'd3);
      dispatch(5'd4);
      dispatch(5'd6);
      dispatch(5'd8);
      dispatch(5'd10);
      chk("t3_busy0", busy_vec, 32'h558);
      exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hA3;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB4;
      #1;
      chk("t3_c1_exu", {31'd0, exu_ready}, 32'd1);
      chk("t3_c1_lsu", {31'd0, lsu_ready}, 32'd0);
      step();
      exu_rd = 5'd6; exu_data = 32'hA6;
      chk("t3_c1_waddr", {27'd0, rf_waddr}, 32'd3);
      chk("t3_c1_wdata", rf_wdata, 32'hA3);
      #1;
      chk("t3_c2_lsu", {31'd0, lsu_ready}, 32'd1);
      chk("t3_c2_exu", {31'd0, exu_ready}, 32'd0);
      step();
      lsu_rd = 5'd8; lsu_data = 32'hB8;
      chk("t3_c2_wen", {31'd0, rf_wen}, 32'd1);
      chk("t3_c2_waddr", {27'd0, rf_waddr}, 32'd4);
      chk("t3_c2_wdata", rf_wdata, 32'hB4);
      chk("t3_c2_busy", busy_vec, 32'h550);
      #1;
      chk("t3_c3_exu", {31'd0, exu_ready}, 32'd1);
      step();
      exu_rd = 5'd10; exu_data = 32'hAA;
      chk("t3_c3_waddr", {27'd0, rf_waddr}, 32'd6);
      chk("t3_c3_busy", busy_vec, 32'h540);
      #1;
      chk("t3_c4_lsu", {31'd0, lsu_ready}, 32'd1);
      chk("t3_c4_exu", {31'd0, exu_ready}, 32'd0);
      step();
      lsu_valid = 1'b0;
      chk("t3_c4_wen", {31'd0, rf_wen}, 32'd1);
      chk("t3_c4_waddr", {27'd0, rf_waddr}, 32'd8);
      chk("t3_c4_wdata", rf_wdata, 32'hB8);
      #1;
      chk("t3_c5_exu", {31'd0, exu_ready}, 32'd1);
      step();
      exu_valid = 1'b0;
      chk("t3_c5_waddr", {27'd0, rf_waddr}, 32'd10);
      chk("t3_c5_wdata", rf_wdata, 32'hAA);
      step();
      chk("t3_end_wen", {31'd0, rf_wen}, 32'd0);
      chk("t3_end_busy", busy_vec, 32'd0);
      chk("t3_end_err", {31'd0, wb_err}, 32'd0);

      // RAW / WAW hazards on x7
      dispatch(5'd7);
      chk("t4_busy", busy_vec, 32'h80);
      iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd7;
      iss_rs1 = 5'd0; iss_rs2 = 5'd0;
      #1;
      chk("t4_waw", {31'd0, iss_stall}, 32'd1);
      iss_rd_en = 1'b0;
      #1;
      chk("t4_nord", {31'd0, iss_stall}, 32'd0);
      iss_rd = 5'd1; iss_rs2 = 5'd7;
      exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
      #1;
      chk("t4_raw", {31'd0, iss_stall}, 32'd1);
      chk("t4_ready", {31'd0, exu_ready}, 32'd1);
      step();
      exu_valid = 1'b0;
      chk("t4_wen", {31'd0, rf_wen}, 32'd1);
      chk("t4_raw_wen", {31'd0, iss_stall}, 32'd1);
      step();
      chk("t4_raw_clr", {31'd0, iss_stall}, 32'd0);
      chk("t4_busy_clr", busy_vec, 32'd0);
      iss_valid = 1'b0; iss_rs2 = 5'd0;

      // writeback to a register that was never marked busy
      exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
      #1;
      chk("t6_ready", {31'd0, exu_ready}, 32'd1);
      chk("t6_err_pre", {31'd0, wb_err}, 32'd0);
      step();
      exu_valid = 1'b0;
      chk("t6_wen", {31'd0, rf_wen}, 32'd1);
      chk("t6_waddr", {27'd0, rf_waddr}, 32'd9);
      chk("t6_wdata", rf_wdata, 32'h99);
      chk("t6_err", {31'd0, wb_err}, 32'd1);
      step();
      step();
      chk("t6_err_sticky", {31'd0, wb_err}, 32'd1);
      chk("t6_wen_off", {31'd0, rf_wen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
